fetch_unit: RTL

//  Program-counter and prefetch stage that sits directly upstream of instruction_memory.
//  - Drives the byte address into instruction_memory.
//  - Captures the combinational 32-bit big-endian instruction word into a small FIFO.
//  - Presents {pc, instr} to decode over a valid/ready handshake.
//  - On a redirect (branch/jump), flushes queued work and restarts fetch at the new PC.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_queue.sv | 88 ++++++++
 rtl/fetch_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Types and constants shared by the fetch stage and its prefetch queue.
//   INSTR_W / ADDR_W   : instruction word and byte-address widths
//   PC_INC             : sequential PC step (one 32-bit word)
//   DEFAULT_RESET_PC   : default PC loaded on reset
//   fetch_entry_t      : one prefetched {pc, instr} pair
//   next_seq_pc()      : sequential next-PC helper (wraps at 2^ADDR_W)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Plain modular add: the PC wraps at the top of the address space.
  function automatic logic [ADDR_W-1:0] next_seq_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_INC;
  endfunction

endpackage : cpu_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Synchronous FIFO of fetch_entry_t used as the prefetch buffer.
//   clk, rst_n   : clock and asynchronous active-low reset
//   i_push       : write i_wr_entry at the tail (accepted if not full, or if
//                  a pop happens in the same cycle)
//   i_pop        : retire the head entry (ignored when empty)
//   i_flush      : discard all entries; overrides push and pop
//   i_wr_entry   : entry to write
//   o_head       : current head entry (holds stale data when empty)
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
// -----------------------------------------------------------------------------
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wr_entry,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_head];

  // A pop frees a slot for a push on the same edge, so a full queue can
  // still stream one entry per cycle.
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

  // NOTE: the storage is reset because the head entry drives out_pc/out_instr
  // directly and those must read zero out of reset; with only a few entries
  // the reset cost is small.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push) begin
      r_mem[r_tail] <= i_wr_entry;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      // Stored data is left in place; only the bookkeeping is cleared.
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Program counter and prefetch stage in front of instruction_memory.
//   clk, rst_n      : clock and asynchronous active-low reset
//   imem_addr       : byte address to instruction memory (= fetch PC)
//   imem_rd_data    : instruction word returned combinationally for imem_addr
//   redirect_valid  : branch/jump redirect this cycle (highest priority)
//   redirect_pc     : redirect target byte address
//   out_valid       : head entry valid toward decode
//   out_ready       : decode accepts the head this cycle
//   out_instr       : head instruction word
//   out_pc          : byte address of out_instr
//   fetch_err       : sticky error (misaligned redirect or PC past the last
//                     word of instruction memory); cleared only by reset
// The fetch PC advances whenever a word is captured; a redirect flushes the
// queue, drops the head, and restarts fetch at the target.
// -----------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int                DEPTH      = 2,
  parameter int                IMEM_BYTES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rd_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fetch_err
);

  // Highest word-aligned byte address that still lies inside the memory.
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(IMEM_BYTES - 4);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic              r_fetch_err;
  logic              w_next_err;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_space;
  logic              w_fetch_ok;
  logic              w_out_of_range;
  logic              w_misalign;
  fetch_entry_t      w_wr_entry;
  fetch_entry_t      w_head;

  // ---------------------------------------------------------------------------
  // Handshake and push qualification
  // ---------------------------------------------------------------------------
  // A redirect kills the head even if decode is ready for it.
  assign w_pop = out_valid && out_ready && !redirect_valid;

  // Room is judged after this cycle's pop so a full queue keeps streaming.
  assign w_space = !w_full || w_pop;

  assign w_out_of_range = (r_fetch_pc > LAST_PC);
  assign w_misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);

  // The stage would fetch this cycle; whether the word is captured or the
  // range error fires instead depends on the current PC.
  assign w_fetch_ok = !redirect_valid && !r_fetch_err && w_space;
  assign w_push     = w_fetch_ok && !w_out_of_range;

  assign w_wr_entry = '{pc: r_fetch_pc, instr: imem_rd_data};

  // ---------------------------------------------------------------------------
  // Next-PC and error priority: redirect > sequential fetch > hold
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_pc  = r_fetch_pc;
    w_next_err = r_fetch_err;
    if (redirect_valid) begin
      w_next_pc = redirect_pc;
      if (w_misalign) begin
        w_next_err = 1'b1;
      end
    end else if (w_push) begin
      w_next_pc = next_seq_pc(r_fetch_pc);
    end else if (w_fetch_ok && w_out_of_range) begin
      // Ran off the end of memory with room to store: stop fetching for good.
      w_next_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_fetch_err <= 1'b0;
    end else begin
      r_fetch_pc  <= w_next_pc;
      r_fetch_err <= w_next_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch queue
  // ---------------------------------------------------------------------------
  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .i_wr_entry (w_wr_entry),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_addr = r_fetch_pc;
  assign out_valid = !w_empty;
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
  assign fetch_err = r_fetch_err;

endmodule : fetch_unit
